mips_pipe: RTL and testbench
============================

# mips_pipe

Five-stage pipelined MIPS integer core (IF, ID, EX, MEM, WB) for the simorgh CPU. It supersedes the multicycle addiu-only core and executes addu, subu, addiu, lw, sw, beq, bne and j. Hazards are handled by a real detection unit, with parametrised forwarding or interlock. A retire port exposes every completed instruction to the testbench.

## Interface
Parameters:
- pc_init, 32'h0: PC loaded at reset.
- sp_init, 32'h0: reset value of $29.
- ra_init, 32'h0: reset value of $31.
- FORWARDING, 1: 1 = EX/MEM and MEM/WB bypass to EX; 0 = interlock only, no bypass to EX.

Ports:
- clk, input, 1: single clock; all state on posedge.
- reset, input, 1: asynchronous, active-low.
- instr_addr, output, 32: fetch PC.
- instr_in, input, 32: instruction at instr_addr, valid combinationally the same cycle.
- data_addr, output, 32: MEM-stage ALU result.
- data_in, input, 32: load data, valid combinationally the same cycle.
- data_out, output, 32: store data (rt value, forwarded).
- data_rd_wr, output, 1: 1 = read/idle, 0 = write this cycle.
- retire_valid, output, 1: WB holds a real, non-bubble instruction.
- retire_pc, output, 32: PC of the retiring instruction.
- retire_wr_en, output, 1: the retiring instruction writes the register file.
- retire_wr_num, output, 5: destination register.
- retire_wr_data, output, 32: value written.

## Operation
- Reset values:
  - instr_addr = pc_init.
  - data_addr = 0, data_out = 0, data_rd_wr = 1.
  - All retire_* = 0.
  - All pipeline valid bits = 0.
  - Registers: $29 = sp_init, $31 = ra_init, others 0.
- Decode:
  - opcode 0x00 with funct 0x21 is addu (rd = rs + rt); funct 0x23 is subu (rd = rs - rt).
  - 0x09 addiu: rt = rs + sext(imm).
  - 0x23 lw: rt = M[rs + sext(imm)].
  - 0x2B sw: M[rs + sext(imm)] = rt.
  - 0x04 beq, 0x05 bne: target = pc + 4 + (sext(imm) << 2).
  - 0x02 j: target = {pc+4[31:28], idx, 2'b00}.
  - Any other encoding is a NOP. It retires with retire_wr_en = 0.
  - Writes to $0 are discarded (retire_wr_en = 0).
- Arithmetic: 32-bit modulo, no overflow traps. No branch delay slots.
- j resolves in ID. The IF instruction is squashed (1 bubble).
- beq/bne resolve in EX using forwarded operands. If taken, IF/ID and ID/EX are squashed (2 bubbles). If not taken, there is no penalty.
- Register file:
  - Uses the existing regfile module.
  - The core adds a WB-to-ID bypass, so a same-cycle write is read in ID.
- Hazards, FORWARDING = 1:
  - Operands are forwarded to EX with priority EX/MEM over MEM/WB.
  - Load-use (lw in EX, consumer in ID) stalls PC and IF/ID for 1 cycle and injects a bubble into EX.
- Hazards, FORWARDING = 0:
  - A consumer in ID stalls while any older valid instruction in EX or MEM writes one of its source registers.
  - Producer in EX costs 2 stall cycles; producer in MEM costs 1.
- Precedence: when a stall and a taken branch occur together, the branch squash wins and the stall is dropped.
- data_rd_wr is 0 only in the single cycle a valid sw occupies MEM.

## Timing
- The instruction at pc_init is fetched in the first posedge after reset deasserts.
- An instruction fetched in cycle n retires (retire_valid = 1) in cycle n+4 if it is not stalled or squashed.
- Sustained throughput is 1 instruction per cycle with no hazards.
- Retire outputs are registered. They describe the WB stage of the current cycle.
- Reset assertion mid-stream clears all valid bits and PC asynchronously. No partial store is issued after reset asserts.

## Structure
- Package mips_pkg:
  - Opcode/funct localparams.
  - Typedefs for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline-register structs, each carrying a valid bit and pc.
  - The fwd_sel_t enum: NONE, EXMEM, MEMWB.
- Sub-module mips_hazard: combinational forwarding-select and stall/squash generation, parametrised by FORWARDING.
- The core instantiates regfile and mips_hazard. Target size is 250–350 lines.

## Test plan
- **Forward ALU:** FORWARDING=1. Run addiu $8,$0,5 then addiu $9,$8,3. Expect $9 = 8 retiring the cycle after $8, with no bubble.
- **Load-use stall:** FORWARDING=1. Run lw $8,0($29) with data_in = 0x1234, then addu $10,$8,$8. Expect exactly 1 bubble (retire_valid = 0) and $10 = 0x2468.
- **Store:** sp_init = 0x100. Run addiu $8,$0,0x55 then sw $8,4($29). Expect data_rd_wr = 0 for exactly 1 cycle, with data_addr = 0x104 and data_out = 0x55.
- **Branch and jump:**
  - beq $0,$0,+2 at 0x10: expect the next retire_pc = 0x1C and 2 bubbles.
  - bne $0,$0: no bubble.
  - j to 0x40: 1 bubble.
- **Interlock mode:** FORWARDING=0. Repeat the forward-ALU case. Expect 2 stall bubbles and $9 = 8.
- **Reset mid-operation:** assert reset while a sw is in EX. Expect:
  - no data_rd_wr = 0 cycle;
  - instr_addr = pc_init immediately;
  - first retire 4 cycles after release.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes, decoded-op enum, forwarding-select enum and the
// four pipeline-register structs of the mips_pipe core.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef enum logic [3:0] {
    I_NOP, I_ADDU, I_SUBU, I_ADDIU, I_LW, I_SW, I_BEQ, I_BNE, I_J
  } op_t;

  typedef enum logic [1:0] {NONE, EXMEM, MEMWB} fwd_sel_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    op_t         op;
    logic [4:0]  rs_num;
    logic [4:0]  rt_num;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic        wr_en;
    logic [4:0]  wr_num;
    logic [31:0] br_target;
  } idex_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        is_lw;
    logic        is_sw;
    logic        wr_en;
    logic [4:0]  wr_num;
    logic [31:0] alu;
    logic [31:0] st_data;
  } exmem_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        wr_en;   // already qualified by valid
    logic [4:0]  wr_num;
    logic [31:0] wr_data;
  } memwb_t;

  // Anything not recognised decodes to I_NOP.
  function automatic op_t decode_op(input logic [31:0] instr);
    op_t op;
    op = I_NOP;
    case (instr[31:26])
      OP_RTYPE: begin
        if (instr[5:0] == FN_ADDU)      op = I_ADDU;
        else if (instr[5:0] == FN_SUBU) op = I_SUBU;
      end
      OP_ADDIU: op = I_ADDIU;
      OP_LW:    op = I_LW;
      OP_SW:    op = I_SW;
      OP_BEQ:   op = I_BEQ;
      OP_BNE:   op = I_BNE;
      OP_J:     op = I_J;
      default:  op = I_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mips_hazard.sv
// mips_hazard: combinational hazard unit for mips_pipe.
// Produces EX operand forwarding selects (EX/MEM beats MEM/WB), the ID stall
// (load-use when FORWARDING=1, full interlock on EX/MEM producers when 0) and
// the IF/ID and ID/EX squash controls. A taken branch overrides any stall.
// Ports: id_* describe the ID instruction, ex_* the ID/EX register,
//        mem_* the EX/MEM register, wb_* the MEM/WB register; br_taken from EX.
module mips_hazard import mips_pkg::*; #(
  parameter bit FORWARDING = 1'b1
) (
  input  logic       id_valid,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_jump,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_valid,
  input  logic       ex_is_lw,
  input  logic       ex_wr_en,
  input  logic [4:0] ex_wr_num,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic       mem_valid,
  input  logic       mem_wr_en,
  input  logic [4:0] mem_wr_num,
  input  logic       wb_wr_en,
  input  logic [4:0] wb_wr_num,
  input  logic       br_taken,
  output fwd_sel_t   fwd_a,
  output fwd_sel_t   fwd_b,
  output logic       stall,
  output logic       flush_ifid,
  output logic       flush_idex
);

  logic ex_hit, mem_hit, stall_raw;
  fwd_sel_t sel_a, sel_b;

  // wr_en is never set for $0 destinations, so no zero-register compare here.
  assign ex_hit  = ex_valid && ex_wr_en &&
                   ((id_use_rs && ex_wr_num == id_rs) || (id_use_rt && ex_wr_num == id_rt));
  assign mem_hit = mem_valid && mem_wr_en &&
                   ((id_use_rs && mem_wr_num == id_rs) || (id_use_rt && mem_wr_num == id_rt));

  // WB producers are covered by the regfile bypass, so only EX/MEM matter.
  assign stall_raw = id_valid && (FORWARDING ? (ex_hit && ex_is_lw) : (ex_hit || mem_hit));

  always_comb begin
    sel_a = NONE;
    sel_b = NONE;
    if (mem_valid && mem_wr_en && mem_wr_num == ex_rs) sel_a = EXMEM;
    else if (wb_wr_en && wb_wr_num == ex_rs)           sel_a = MEMWB;
    if (mem_valid && mem_wr_en && mem_wr_num == ex_rt) sel_b = EXMEM;
    else if (wb_wr_en && wb_wr_num == ex_rt)           sel_b = MEMWB;
  end

  assign fwd_a      = FORWARDING ? sel_a : NONE;
  assign fwd_b      = FORWARDING ? sel_b : NONE;
  assign stall      = stall_raw && !br_taken;
  assign flush_idex = br_taken || stall_raw;
  assign flush_ifid = br_taken || id_jump;

endmodule

// File: rtl/regfile.sv
// regfile: 32 x 32-bit register file, two async read ports, one write port.
// $0 reads as zero and ignores writes. $29/$31 take parameterised reset values.
// Ports: clk, reset (async, active-low), rs_num/rt_num -> rs_data/rt_data,
//        wr_en/wr_num/wr_data (written on posedge).
module regfile #(
  parameter logic [31:0] sp_init = 32'h0,
  parameter logic [31:0] ra_init = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_num,
  input  logic [4:0]  rt_num,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  input  logic        wr_en,
  input  logic [4:0]  wr_num,
  input  logic [31:0] wr_data
);

  logic [31:0][31:0] regs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs     <= '0;
      regs[29] <= sp_init;
      regs[31] <= ra_init;
    end else if (wr_en && wr_num != 5'd0) begin
      regs[wr_num] <= wr_data;
    end
  end

  assign rs_data = (rs_num == 5'd0) ? 32'h0 : regs[rs_num];
  assign rt_data = (rt_num == 5'd0) ? 32'h0 : regs[rt_num];

endmodule

// File: rtl/mips_pipe.sv
// mips_pipe: five-stage (IF ID EX MEM WB) MIPS integer core executing addu,
// subu, addiu, lw, sw, beq, bne, j. j resolves in ID (1 bubble), beq/bne in EX
// (2 bubbles when taken). No delay slots.
// Ports: clk, reset (async, active-low); instr_addr/instr_in fetch port;
//        data_addr/data_in/data_out/data_rd_wr data port (rd_wr=0 on store);
//        retire_* describe the instruction currently in WB.
module mips_pipe import mips_pkg::*; #(
  parameter logic [31:0] pc_init    = 32'h0,
  parameter logic [31:0] sp_init    = 32'h0,
  parameter logic [31:0] ra_init    = 32'h0,
  parameter bit          FORWARDING = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_in,
  output logic [31:0] data_addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_rd_wr,
  output logic        retire_valid,
  output logic [31:0] retire_pc,
  output logic        retire_wr_en,
  output logic [4:0]  retire_wr_num,
  output logic [31:0] retire_wr_data
);

  logic [31:0] pc;
  ifid_t  ifid;
  idex_t  idex;
  exmem_t exmem;
  memwb_t memwb;

  // ---------------- ID ----------------
  op_t         id_op;
  logic [4:0]  id_rs, id_rt, id_rd, id_dst;
  logic        id_use_rs, id_use_rt, id_has_dst, id_wr_en, id_jump;
  logic [31:0] id_imm, id_pc4, id_br_target, id_j_target;
  logic [31:0] rf_rs, rf_rt, id_rs_val, id_rt_val;

  assign id_op        = decode_op(ifid.instr);
  assign id_rs        = ifid.instr[25:21];
  assign id_rt        = ifid.instr[20:16];
  assign id_rd        = ifid.instr[15:11];
  assign id_imm       = {{16{ifid.instr[15]}}, ifid.instr[15:0]};
  assign id_pc4       = ifid.pc + 32'd4;
  assign id_br_target = id_pc4 + {id_imm[29:0], 2'b00};
  assign id_j_target  = {id_pc4[31:28], ifid.instr[25:0], 2'b00};

  assign id_use_rs  = id_op inside {I_ADDU, I_SUBU, I_ADDIU, I_LW, I_SW, I_BEQ, I_BNE};
  assign id_use_rt  = id_op inside {I_ADDU, I_SUBU, I_SW, I_BEQ, I_BNE};
  assign id_has_dst = id_op inside {I_ADDU, I_SUBU, I_ADDIU, I_LW};
  assign id_dst     = (id_op inside {I_ADDU, I_SUBU}) ? id_rd : id_rt;
  assign id_wr_en   = id_has_dst && (id_dst != 5'd0);
  assign id_jump    = ifid.valid && (id_op == I_J);

  regfile #(.sp_init(sp_init), .ra_init(ra_init)) u_rf (
    .clk     (clk),
    .reset   (reset),
    .rs_num  (id_rs),
    .rt_num  (id_rt),
    .rs_data (rf_rs),
    .rt_data (rf_rt),
    .wr_en   (memwb.wr_en),
    .wr_num  (memwb.wr_num),
    .wr_data (memwb.wr_data)
  );

  // WB-to-ID bypass: a value being written this cycle is visible in ID.
  assign id_rs_val = (memwb.wr_en && memwb.wr_num == id_rs) ? memwb.wr_data : rf_rs;
  assign id_rt_val = (memwb.wr_en && memwb.wr_num == id_rt) ? memwb.wr_data : rf_rt;

  // ---------------- EX ----------------
  fwd_sel_t    fwd_a, fwd_b;
  logic [31:0] ex_a, ex_b, ex_alu;
  logic        br_taken, stall, flush_ifid, flush_idex;

  always_comb begin
    case (fwd_a)
      EXMEM:   ex_a = exmem.alu;
      MEMWB:   ex_a = memwb.wr_data;
      default: ex_a = idex.rs_val;
    endcase
    case (fwd_b)
      EXMEM:   ex_b = exmem.alu;
      MEMWB:   ex_b = memwb.wr_data;
      default: ex_b = idex.rt_val;
    endcase
    case (idex.op)
      I_ADDU:              ex_alu = ex_a + ex_b;
      I_SUBU:              ex_alu = ex_a - ex_b;
      I_ADDIU, I_LW, I_SW: ex_alu = ex_a + idex.imm;
      default:             ex_alu = 32'h0;
    endcase
    br_taken = idex.valid && ((idex.op == I_BEQ && ex_a == ex_b) ||
                              (idex.op == I_BNE && ex_a != ex_b));
  end

  mips_hazard #(.FORWARDING(FORWARDING)) u_hz (
    .id_valid   (ifid.valid),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .id_jump    (id_jump),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .ex_valid   (idex.valid),
    .ex_is_lw   (idex.op == I_LW),
    .ex_wr_en   (idex.wr_en),
    .ex_wr_num  (idex.wr_num),
    .ex_rs      (idex.rs_num),
    .ex_rt      (idex.rt_num),
    .mem_valid  (exmem.valid),
    .mem_wr_en  (exmem.wr_en),
    .mem_wr_num (exmem.wr_num),
    .wb_wr_en   (memwb.wr_en),
    .wb_wr_num  (memwb.wr_num),
    .br_taken   (br_taken),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .stall      (stall),
    .flush_ifid (flush_ifid),
    .flush_idex (flush_idex)
  );

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= pc_init;
      ifid  <= '0;
      idex  <= '0;
      exmem <= '0;
      memwb <= '0;
    end else begin
      // IF
      if (br_taken)    pc <= idex.br_target;
      else if (!stall) pc <= id_jump ? id_j_target : pc + 32'd4;

      if (flush_ifid) begin
        ifid <= '0;
      end else if (!stall) begin
        ifid.valid <= 1'b1;
        ifid.pc    <= pc;
        ifid.instr <= instr_in;
      end

      // ID -> EX; a stall or taken branch leaves a bubble behind
      if (flush_idex) begin
        idex <= '0;
      end else begin
        idex.valid     <= ifid.valid;
        idex.pc        <= ifid.pc;
        idex.op        <= id_op;
        idex.rs_num    <= id_rs;
        idex.rt_num    <= id_rt;
        idex.rs_val    <= id_rs_val;
        idex.rt_val    <= id_rt_val;
        idex.imm       <= id_imm;
        idex.wr_en     <= id_wr_en;
        idex.wr_num    <= id_dst;
        idex.br_target <= id_br_target;
      end

      // EX -> MEM
      exmem.valid   <= idex.valid;
      exmem.pc      <= idex.pc;
      exmem.is_lw   <= idex.op == I_LW;
      exmem.is_sw   <= idex.op == I_SW;
      exmem.wr_en   <= idex.wr_en;
      exmem.wr_num  <= idex.wr_num;
      exmem.alu     <= ex_alu;
      exmem.st_data <= ex_b;

      // MEM -> WB
      memwb.valid   <= exmem.valid;
      memwb.pc      <= exmem.pc;
      memwb.wr_en   <= exmem.valid && exmem.wr_en;
      memwb.wr_num  <= exmem.wr_num;
      memwb.wr_data <= exmem.is_lw ? data_in : exmem.alu;
    end
  end

  assign instr_addr     = pc;
  assign data_addr      = exmem.alu;
  assign data_out       = exmem.st_data;
  assign data_rd_wr     = !(exmem.valid && exmem.is_sw);
  assign retire_valid   = memwb.valid;
  assign retire_pc      = memwb.pc;
  assign retire_wr_en   = memwb.wr_en;
  assign retire_wr_num  = memwb.wr_num;
  assign retire_wr_data = memwb.wr_data;

endmodule

// File: tb/tb_mips_pipe.sv
// tb_mips_pipe: directed tests for mips_pipe. Two cores share one program
// memory and reset: u_fwd (FORWARDING=1) and u_ilk (FORWARDING=0).
// Cycle c below means the cycle after c posedges since reset release; the
// instruction at pc_init is fetched in cycle 0 and retires in cycle 4.
module tb_mips_pipe;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] imem [0:63];

  logic [31:0] f_iaddr, f_iin, f_daddr, f_din, f_dout, f_rpc, f_rdata;
  logic        f_drw, f_rv, f_rwe;
  logic [4:0]  f_rnum;
  logic [31:0] i_iaddr, i_iin, i_daddr, i_din, i_dout, i_rpc, i_rdata;
  logic        i_drw, i_rv, i_rwe;
  logic [4:0]  i_rnum;

  assign f_iin = imem[f_iaddr[7:2]];
  assign i_iin = imem[i_iaddr[7:2]];
  assign f_din = (f_daddr == 32'h100) ? 32'h1234 : 32'hDEAD_BEEF;
  assign i_din = (i_daddr == 32'h100) ? 32'h1234 : 32'hDEAD_BEEF;

  mips_pipe #(.pc_init(32'h0), .sp_init(32'h100), .ra_init(32'h200), .FORWARDING(1'b1)) u_fwd (
    .clk(clk), .reset(reset), .instr_addr(f_iaddr), .instr_in(f_iin),
    .data_addr(f_daddr), .data_in(f_din), .data_out(f_dout), .data_rd_wr(f_drw),
    .retire_valid(f_rv), .retire_pc(f_rpc), .retire_wr_en(f_rwe),
    .retire_wr_num(f_rnum), .retire_wr_data(f_rdata));

  mips_pipe #(.pc_init(32'h0), .sp_init(32'h100), .ra_init(32'h200), .FORWARDING(1'b0)) u_ilk (
    .clk(clk), .reset(reset), .instr_addr(i_iaddr), .instr_in(i_iin),
    .data_addr(i_daddr), .data_in(i_din), .data_out(i_dout), .data_rd_wr(i_drw),
    .retire_valid(i_rv), .retire_pc(i_rpc), .retire_wr_en(i_rwe),
    .retire_wr_num(i_rnum), .retire_wr_data(i_rdata));

  int errors = 0;
  int checks = 0;

  // per-cycle snapshots
  logic        s_rv [32];
  logic        s_rwe [32];
  logic [4:0]  s_rnum [32];
  logic [31:0] s_rpc [32];
  logic [31:0] s_rdata [32];
  logic        s_drw [32];
  logic [31:0] s_daddr [32];
  logic [31:0] s_dout [32];
  logic        t_rv [32];
  logic [4:0]  t_rnum [32];
  logic [31:0] t_rpc [32];
  logic [31:0] t_rdata [32];

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
  endtask

  task automatic snap(input int c);
    s_rv[c] = f_rv;  s_rwe[c] = f_rwe;  s_rnum[c] = f_rnum;  s_rpc[c] = f_rpc;
    s_rdata[c] = f_rdata;  s_drw[c] = f_drw;  s_daddr[c] = f_daddr;  s_dout[c] = f_dout;
    t_rv[c] = i_rv;  t_rnum[c] = i_rnum;  t_rpc[c] = i_rpc;  t_rdata[c] = i_rdata;
  endtask

  // Release reset on a negedge and capture n cycles.
  task automatic run(input int n);
    @(negedge clk);
    reset = 1'b1;
    #1 snap(0);
    for (int c = 1; c < n; c++) begin
      @(negedge clk);
      #1 snap(c);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    checks++; if (f_iaddr !== 32'h0) begin errors++; $display("FAIL rst_iaddr: got %h want 0", f_iaddr); end
    checks++; if (f_drw !== 1'b1) begin errors++; $display("FAIL rst_drw: got %b want 1", f_drw); end
    checks++; if (f_daddr !== 32'h0 || f_dout !== 32'h0) begin errors++; $display("FAIL rst_data: got addr %h out %h want 0 0", f_daddr, f_dout); end
    checks++; if ({f_rv, f_rwe, f_rnum, f_rpc, f_rdata} !== '0) begin errors++; $display("FAIL rst_retire: got v%b we%b n%0d pc %h d %h want all 0", f_rv, f_rwe, f_rnum, f_rpc, f_rdata); end
    checks++; if (i_rv !== 1'b0 || i_iaddr !== 32'h0) begin errors++; $display("FAIL rst_ilk: got rv %b iaddr %h want 0 0", i_rv, i_iaddr); end
  endtask

  task automatic test_fwd_alu();
    reset = 1'b0; clear_imem();
    imem[0] = enc_i(6'h09, 5'd0, 5'd8, 16'd5);
    imem[1] = enc_i(6'h09, 5'd8, 5'd9, 16'd3);
    run(10);
    checks++; if ({s_rv[4], s_rwe[4], s_rnum[4], s_rpc[4], s_rdata[4]} !== {1'b1, 1'b1, 5'd8, 32'h0, 32'd5})
      begin errors++; $display("FAIL fwd_first: got v%b we%b n%0d pc %h d %h want 1 1 8 0 5", s_rv[4], s_rwe[4], s_rnum[4], s_rpc[4], s_rdata[4]); end
    checks++; if ({s_rv[5], s_rwe[5], s_rnum[5], s_rpc[5], s_rdata[5]} !== {1'b1, 1'b1, 5'd9, 32'h4, 32'd8})
      begin errors++; $display("FAIL fwd_second: got v%b we%b n%0d pc %h d %h want 1 1 9 4 8", s_rv[5], s_rwe[5], s_rnum[5], s_rpc[5], s_rdata[5]); end
    checks++; if (s_rv[3] !== 1'b0) begin errors++; $display("FAIL fwd_latency: got rv %b in cycle 3 want 0", s_rv[3]); end
    // same program in interlock mode: two bubbles before $9
    checks++; if (t_rv[4] !== 1'b1 || t_rdata[4] !== 32'd5) begin errors++; $display("FAIL ilk_first: got v%b d %h want 1 5", t_rv[4], t_rdata[4]); end
    checks++; if (t_rv[5] !== 1'b0 || t_rv[6] !== 1'b0) begin errors++; $display("FAIL ilk_bubbles: got %b%b want 00", t_rv[5], t_rv[6]); end
    checks++; if ({t_rv[7], t_rnum[7], t_rpc[7], t_rdata[7]} !== {1'b1, 5'd9, 32'h4, 32'd8})
      begin errors++; $display("FAIL ilk_second: got v%b n%0d pc %h d %h want 1 9 4 8", t_rv[7], t_rnum[7], t_rpc[7], t_rdata[7]); end
  endtask

  task automatic test_load_use();
    reset = 1'b0; clear_imem();
    imem[0] = enc_i(6'h23, 5'd29, 5'd8, 16'd0);
    imem[1] = enc_r(5'd8, 5'd8, 5'd10, 6'h21);
    run(10);
    checks++; if ({s_rv[4], s_rnum[4], s_rdata[4]} !== {1'b1, 5'd8, 32'h1234}) begin errors++; $display("FAIL lu_load: got v%b n%0d d %h want 1 8 1234", s_rv[4], s_rnum[4], s_rdata[4]); end
    checks++; if (s_rv[5] !== 1'b0) begin errors++; $display("FAIL lu_bubble: got rv %b want 0", s_rv[5]); end
    checks++; if ({s_rv[6], s_rnum[6], s_rpc[6], s_rdata[6]} !== {1'b1, 5'd10, 32'h4, 32'h2468})
      begin errors++; $display("FAIL lu_use: got v%b n%0d pc %h d %h want 1 10 4 2468", s_rv[6], s_rnum[6], s_rpc[6], s_rdata[6]); end
    checks++; if (s_rv[7] !== 1'b1 || s_rpc[7] !== 32'h8) begin errors++; $display("FAIL lu_after: got v%b pc %h want 1 8", s_rv[7], s_rpc[7]); end
  endtask

  task automatic test_store();
    int nwr;
    reset = 1'b0; clear_imem();
    imem[0] = enc_i(6'h09, 5'd0, 5'd8, 16'h55);
    imem[1] = enc_i(6'h2B, 5'd29, 5'd8, 16'd4);
    run(12);
    nwr = 0;
    for (int c = 0; c < 12; c++) if (s_drw[c] === 1'b0) nwr++;
    checks++; if (nwr != 1) begin errors++; $display("FAIL st_count: got %0d write cycles want 1", nwr); end
    checks++; if ({s_drw[4], s_daddr[4], s_dout[4]} !== {1'b0, 32'h104, 32'h55})
      begin errors++; $display("FAIL st_bus: got rdwr %b addr %h out %h want 0 104 55", s_drw[4], s_daddr[4], s_dout[4]); end
    checks++; if ({s_rv[5], s_rwe[5], s_rpc[5]} !== {1'b1, 1'b0, 32'h4}) begin errors++; $display("FAIL st_retire: got v%b we%b pc %h want 1 0 4", s_rv[5], s_rwe[5], s_rpc[5]); end
  endtask

  task automatic test_branch();
    // beq $0,$0,+2 at 0x10 -> 0x1C, two bubbles
    reset = 1'b0; clear_imem();
    imem[4] = enc_i(6'h04, 5'd0, 5'd0, 16'd2);
    imem[5] = enc_i(6'h09, 5'd0, 5'd1, 16'd1);
    imem[6] = enc_i(6'h09, 5'd0, 5'd1, 16'd2);
    imem[7] = enc_i(6'h09, 5'd0, 5'd2, 16'd7);
    run(14);
    checks++; if (s_rv[8] !== 1'b1 || s_rpc[8] !== 32'h10) begin errors++; $display("FAIL beq_retire: got v%b pc %h want 1 10", s_rv[8], s_rpc[8]); end
    checks++; if (s_rv[9] !== 1'b0 || s_rv[10] !== 1'b0) begin errors++; $display("FAIL beq_bubbles: got %b%b want 00", s_rv[9], s_rv[10]); end
    checks++; if ({s_rv[11], s_rpc[11], s_rnum[11], s_rdata[11]} !== {1'b1, 32'h1C, 5'd2, 32'd7})
      begin errors++; $display("FAIL beq_target: got v%b pc %h n%0d d %h want 1 1c 2 7", s_rv[11], s_rpc[11], s_rnum[11], s_rdata[11]); end
    // j 0x40 (1 bubble), then bne $0,$0 not taken (no bubble)
    reset = 1'b0; clear_imem();
    imem[0]  = {6'h02, 26'h10};
    imem[1]  = enc_i(6'h09, 5'd0, 5'd1, 16'd1);
    imem[16] = enc_i(6'h05, 5'd0, 5'd0, 16'd2);
    imem[17] = enc_i(6'h09, 5'd0, 5'd3, 16'd9);
    run(10);
    checks++; if ({s_rv[4], s_rwe[4], s_rpc[4]} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL j_retire: got v%b we%b pc %h want 1 0 0", s_rv[4], s_rwe[4], s_rpc[4]); end
    checks++; if (s_rv[5] !== 1'b0) begin errors++; $display("FAIL j_bubble: got rv %b want 0", s_rv[5]); end
    checks++; if (s_rv[6] !== 1'b1 || s_rpc[6] !== 32'h40) begin errors++; $display("FAIL j_target: got v%b pc %h want 1 40", s_rv[6], s_rpc[6]); end
    checks++; if ({s_rv[7], s_rpc[7], s_rdata[7]} !== {1'b1, 32'h44, 32'd9}) begin errors++; $display("FAIL bne_fall: got v%b pc %h d %h want 1 44 9", s_rv[7], s_rpc[7], s_rdata[7]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e_pc [10];
    logic [4:0]  e_num [10];
    logic        e_we [10];
    logic [31:0] e_dat [10];
    reset = 1'b0; clear_imem();
    imem[0] = enc_i(6'h09, 5'd0, 5'd8, 16'd1);     // $8 = 1
    imem[1] = enc_i(6'h09, 5'd0, 5'd9, 16'd2);     // $9 = 2
    imem[2] = enc_r(5'd8, 5'd9, 5'd10, 6'h21);     // $10 = 3
    imem[3] = enc_r(5'd10, 5'd8, 5'd11, 6'h23);    // $11 = 2
    imem[4] = enc_i(6'h09, 5'd11, 5'd11, 16'd5);   // $11 = 7
    imem[5] = enc_i(6'h09, 5'd11, 5'd11, 16'd1);   // $11 = 8 (EX/MEM wins)
    imem[6] = enc_i(6'h09, 5'd0, 5'd0, 16'd5);     // write to $0
    imem[7] = 32'hFC00_0000;                       // unknown opcode
    imem[8] = enc_r(5'd31, 5'd29, 5'd12, 6'h21);   // $12 = 0x200 + 0x100
    imem[9] = enc_r(5'd0, 5'd8, 5'd13, 6'h23);     // $13 = 0 - 1
    e_pc  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24};
    e_num = '{5'd8, 5'd9, 5'd10, 5'd11, 5'd11, 5'd11, 5'd0, 5'd0, 5'd12, 5'd13};
    e_we  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    e_dat = '{32'd1, 32'd2, 32'd3, 32'd2, 32'd7, 32'd8, 32'd0, 32'd0, 32'h300, 32'hFFFF_FFFF};
    run(16);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (s_rv[k+4] !== 1'b1 || s_rpc[k+4] !== e_pc[k] || s_rwe[k+4] !== e_we[k]) begin
        errors++;
        $display("FAIL b2b_retire[%0d]: got v%b pc %h we%b want 1 %h %b", k, s_rv[k+4], s_rpc[k+4], s_rwe[k+4], e_pc[k], e_we[k]);
      end
      if (e_we[k]) begin
        checks++;
        if (s_rnum[k+4] !== e_num[k] || s_rdata[k+4] !== e_dat[k]) begin
          errors++;
          $display("FAIL b2b_data[%0d]: got n%0d d %h want n%0d d %h", k, s_rnum[k+4], s_rdata[k+4], e_num[k], e_dat[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int nwr;
    reset = 1'b0; clear_imem();
    imem[0] = enc_i(6'h09, 5'd0, 5'd8, 16'h55);
    imem[1] = enc_i(6'h2B, 5'd29, 5'd8, 16'd4);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);   // cycle 3: sw sits in EX
    #1 reset = 1'b0;
    #1;
    checks++; if (f_iaddr !== 32'h0) begin errors++; $display("FAIL mid_iaddr: got %h want 0", f_iaddr); end
    nwr = 0;
    if (f_drw !== 1'b1) nwr++;
    repeat (3) begin
      @(posedge clk); #1;
      if (f_drw !== 1'b1) nwr++;
    end
    run(8);
    for (int c = 0; c < 4; c++) if (s_drw[c] !== 1'b1) nwr++;
    checks++; if (nwr != 0) begin errors++; $display("FAIL mid_store: got %0d write cycles want 0", nwr); end
    checks++; if ({s_rv[1], s_rv[2], s_rv[3]} !== 3'b000) begin errors++; $display("FAIL mid_early: got %b want 000", {s_rv[1], s_rv[2], s_rv[3]}); end
    checks++; if (s_rv[4] !== 1'b1 || s_rpc[4] !== 32'h0 || s_rdata[4] !== 32'h55)
      begin errors++; $display("FAIL mid_first: got v%b pc %h d %h want 1 0 55", s_rv[4], s_rpc[4], s_rdata[4]); end
  endtask

  initial begin
    test_reset();
    test_fwd_alu();
    test_load_use();
    test_store();
    test_branch();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
